// File: rtl/alu_resp_checker.sv
// rtl/alu_resp_checker.sv - two-stage ALU response checker; ALU_CHK_FLAGS_EN adds zero/carry/overflow compare
module alu_resp_checker #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           op,
    input  logic                 dir,
    input  logic [WIDTH-1:0]     dut_result,
    input  logic                 dut_zero,
    input  logic                 dut_carry,
    input  logic                 dut_overflow,
    output logic                 pass_pulse,
    output logic                 fail_pulse,
    output logic [CNT_WIDTH-1:0] pass_count,
    output logic [CNT_WIDTH-1:0] fail_count,
    output logic                 err_sticky,
    output logic [WIDTH-1:0]     ff_a,
    output logic [WIDTH-1:0]     ff_b,
    output logic [2:0]           ff_op,
    output logic                 ff_dir,
    output logic [WIDTH-1:0]     ff_exp,
    output logic [WIDTH-1:0]     ff_got
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic             s1_dir;
    logic [WIDTH-1:0] s1_result;
    logic [WIDTH-1:0] exp_result;
    logic             match;

    always_comb begin
        exp_result = '0;
        case (s1_op)
            3'd0:    exp_result = s1_a + s1_b;
            3'd1:    exp_result = s1_a - s1_b;
            3'd2:    exp_result = s1_a & s1_b;
            3'd3:    exp_result = s1_a | s1_b;
            3'd4:    exp_result = s1_a ^ s1_b;
            3'd5:    exp_result = s1_dir ? {1'b0, s1_a[WIDTH-1:1]} : {s1_a[WIDTH-2:0], 1'b0};
            default: exp_result = '0;
        endcase
    end

`ifdef ALU_CHK_FLAGS_EN
    logic           s1_zero;
    logic           s1_carry;
    logic           s1_overflow;
    logic           exp_carry;
    logic           exp_overflow;
    logic [WIDTH:0] add_ext;
    logic [WIDTH:0] sub_ext;

    assign add_ext = {1'b0, s1_a} + {1'b0, s1_b};
    assign sub_ext = {1'b0, s1_a} - {1'b0, s1_b};

    always_comb begin
        exp_carry    = 1'b0;
        exp_overflow = 1'b0;
        case (s1_op)
            3'd0: begin
                exp_carry    = add_ext[WIDTH];
                exp_overflow = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (add_ext[WIDTH-1] != s1_a[WIDTH-1]);
            end
            3'd1: begin
                // carry reports the unsigned borrow
                exp_carry    = sub_ext[WIDTH];
                exp_overflow = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (sub_ext[WIDTH-1] != s1_a[WIDTH-1]);
            end
            3'd5:    exp_carry = s1_dir ? s1_a[0] : s1_a[WIDTH-1];
            default: exp_carry = 1'b0;
        endcase
    end

    assign match = (exp_result == s1_result) && ((exp_result == '0) == s1_zero)
                && (exp_carry == s1_carry) && (exp_overflow == s1_overflow);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_zero     <= 1'b0;
            s1_carry    <= 1'b0;
            s1_overflow <= 1'b0;
        end else begin
            s1_zero     <= dut_zero;
            s1_carry    <= dut_carry;
            s1_overflow <= dut_overflow;
        end
    end
`else
    logic unused_flags;
    assign unused_flags = ^{dut_zero, dut_carry, dut_overflow};
    assign match = (exp_result == s1_result);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_op     <= '0;
            s1_dir    <= 1'b0;
            s1_result <= '0;
        end else begin
            s1_valid  <= in_valid;
            s1_a      <= a;
            s1_b      <= b;
            s1_op     <= op;
            s1_dir    <= dir;
            s1_result <= dut_result;
        end
    end

    // clr discards the completing transaction but not the one entering stage 1
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pass_pulse <= 1'b0;
            fail_pulse <= 1'b0;
            pass_count <= '0;
            fail_count <= '0;
            err_sticky <= 1'b0;
            ff_a       <= '0;
            ff_b       <= '0;
            ff_op      <= '0;
            ff_dir     <= 1'b0;
            ff_exp     <= '0;
            ff_got     <= '0;
        end else begin
            pass_pulse <= s1_valid && match;
            fail_pulse <= s1_valid && !match;
            if (s1_valid && match && pass_count != CNT_MAX)
                pass_count <= pass_count + CNT_WIDTH'(1);
            if (s1_valid && !match) begin
                if (fail_count != CNT_MAX)
                    fail_count <= fail_count + CNT_WIDTH'(1);
                if (!err_sticky) begin
                    err_sticky <= 1'b1;
                    ff_a       <= s1_a;
                    ff_b       <= s1_b;
                    ff_op      <= s1_op;
                    ff_dir     <= s1_dir;
                    ff_exp     <= exp_result;
                    ff_got     <= s1_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_resp_checker.sv
// tb/tb_alu_resp_checker.sv - scoreboard bench for alu_resp_checker
module tb_alu_resp_checker;

`ifdef ALU_CHK_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] a = '0, b = '0, dut_result = '0;
    logic [2:0] op = '0;
    logic       dir = 1'b0, dut_zero = 1'b0, dut_carry = 1'b0, dut_overflow = 1'b0;
    logic       pass_pulse, fail_pulse, err_sticky, ff_dir;
    logic [3:0] pass_count, fail_count;
    logic [7:0] ff_a, ff_b, ff_exp, ff_got;
    logic [2:0] ff_op;

    int total = 0;
    int bad = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    alu_resp_checker #(.WIDTH(8), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
        .a(a), .b(b), .op(op), .dir(dir),
        .dut_result(dut_result), .dut_zero(dut_zero), .dut_carry(dut_carry), .dut_overflow(dut_overflow),
        .pass_pulse(pass_pulse), .fail_pulse(fail_pulse),
        .pass_count(pass_count), .fail_count(fail_count), .err_sticky(err_sticky),
        .ff_a(ff_a), .ff_b(ff_b), .ff_op(ff_op), .ff_dir(ff_dir), .ff_exp(ff_exp), .ff_got(ff_got)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // monitor: every pulse consumes the oldest expected outcome
    always @(negedge clk) begin
        if (pass_pulse && fail_pulse) begin
            total++;
            bad++;
            $display("FAIL pulse_excl got=both want=one");
        end else if (pass_pulse || fail_pulse) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse got=pass:%0b want=none", pass_pulse);
            end else begin
                bit want;
                want = exp_q.pop_front();
                if (pass_pulse !== want) begin
                    bad++;
                    $display("FAIL pulse_kind got=pass:%0b want=pass:%0b", pass_pulse, want);
                end
            end
        end
    end

    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] top, input logic tdir,
                        input logic [7:0] tres, input logic tz, input logic tc, input logic tv,
                        input bit want_pass, input bit push);
        in_valid = 1'b1;
        a = ta; b = tb; op = top; dir = tdir;
        dut_result = tres; dut_zero = tz; dut_carry = tc; dut_overflow = tv;
        if (push) exp_q.push_back(want_pass);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_pass_count", pass_count, 0);
        chk("rst_fail_count", fail_count, 0);
        chk("rst_sticky", err_sticky, 0);
        chk("rst_pulses", {pass_pulse, fail_pulse}, 0);
        chk("rst_ff", {ff_a, ff_b, ff_op, ff_dir, ff_exp, ff_got}, 0);
        rst = 1'b0;

        // ADD 200+100 = 44 with carry
        send(8'd200, 8'd100, 3'd0, 1'b0, 8'd44, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(1);
        chk("add_pass_count", pass_count, 1);

        // overflow / borrow / shift / unused opcode
        send(8'd127, 8'd1, 3'd0, 1'b0, 8'd128, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        send(8'd5, 8'd10, 3'd1, 1'b0, 8'd251, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        send(8'h81, 8'h00, 3'd5, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        send(8'h81, 8'h00, 3'd5, 1'b1, 8'h40, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        send(8'h55, 8'h33, 3'd6, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);
        chk("flags_pass_count", pass_count, 6);
        chk("flags_fail_count", fail_count, 0);

        // back-to-back: correct, wrong, wrong
        pulse_clr();
        chk("clr_pass_count", pass_count, 0);
        send(8'h0F, 8'hF0, 3'd3, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send(8'hF0, 8'h3C, 3'd2, 1'b0, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(8'hAA, 8'h55, 3'd4, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        chk("b2b_fail_count", fail_count, 2);
        chk("b2b_pass_count", pass_count, 1);
        chk("b2b_sticky", err_sticky, 1);
        chk("ff_a", ff_a, 8'hF0);
        chk("ff_b", ff_b, 8'h3C);
        chk("ff_op", ff_op, 2);
        chk("ff_dir", ff_dir, 0);
        chk("ff_exp", ff_exp, 8'h30);
        chk("ff_got", ff_got, 8'h31);

        // carry-only error
        pulse_clr();
        send(8'd200, 8'd100, 3'd0, 1'b0, 8'd44, 1'b0, 1'b0, 1'b0, !FLAGS_EN, 1'b1);
        idle(2);
        chk("flagerr_fail_count", fail_count, FLAGS_EN ? 1 : 0);
        chk("flagerr_sticky", err_sticky, FLAGS_EN ? 1 : 0);
        chk("flagerr_ff_got", ff_got, FLAGS_EN ? 44 : 0);

        // saturation, then clr on a completing transaction
        pulse_clr();
        for (int i = 1; i <= 20; i++)
            send(8'(i), 8'hFF, 3'd2, 1'b0, 8'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send(8'h01, 8'h01, 3'd0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("sat_pass_count", pass_count, 15);
        clr = 1'b1;
        send(8'h03, 8'h01, 3'd1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        clr = 1'b0;
        chk("clr_hit_pass_count", pass_count, 0);
        chk("clr_hit_pulses", {pass_pulse, fail_pulse}, 0);
        idle(1);
        chk("post_clr_pass_count", pass_count, 1);

        // reset mid-stream drops both in-flight transactions
        send(8'h10, 8'h10, 3'd0, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        send(8'h20, 8'h20, 3'd0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("midrst_counts", {pass_count, fail_count}, 0);
        chk("midrst_flags", {pass_pulse, fail_pulse, err_sticky}, 0);
        chk("midrst_ff", {ff_a, ff_b, ff_op, ff_dir, ff_exp, ff_got}, 0);
        idle(3);
        chk("post_rst_fail_count", fail_count, 0);

        for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_resp_checker.md
# alu_resp_checker

Synthesizable response checker that sits on the output side of the `ALU` datapath. Each cycle it captures one stimulus/response pair (`a`, `b`, `op`, `dir` plus the ALU's `result`/`zero`/`carry`/`overflow`) and recomputes the expected response in a two-stage pipeline. It compares the two, keeps saturating pass/fail counters, and latches the first mismatching transaction for debug readout. It lets the ALU be self-checked on-chip or in long random regressions without a software scoreboard.

## Interface
- `WIDTH`, 8, operand/result width; matches the ALU instance.
- `CNT_WIDTH`, 16, width of the pass/fail counters.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `clr` in 1: synchronous clear of counters, sticky error and capture registers.
- `in_valid` in 1: the current `a`/`b`/`op`/`dir` and ALU outputs form one transaction.
- `a`, `b` in WIDTH: operands applied to the ALU.
- `op` in 3: ALU opcode.
- `dir` in 1: shift direction (0 = left, 1 = right).
- `dut_result` in WIDTH: ALU `result`.
- `dut_zero`, `dut_carry`, `dut_overflow` in 1 each: ALU flags.
- `pass_pulse` out 1: one-cycle pulse for a matching transaction.
- `fail_pulse` out 1: one-cycle pulse for a mismatching transaction.
- `pass_count`, `fail_count` out CNT_WIDTH: saturating counters.
- `err_sticky` out 1: set on the first mismatch; held until `clr`/`rst`.
- `ff_a`, `ff_b` out WIDTH: operands of the first failing transaction.
- `ff_op` out 3, `ff_dir` out 1: opcode and direction of the first failing transaction.
- `ff_exp` out WIDTH: expected result of the first failing transaction.
- `ff_got` out WIDTH: observed result of the first failing transaction.

## Operation
Reference model, all arithmetic modulo 2^WIDTH:
- op 0, ADD: result = a+b. carry = carry-out of bit WIDTH-1. overflow = signed overflow (operands share a sign that differs from the result's sign).
- op 1, SUB: result = a−b. carry = 1 iff a<b unsigned (borrow). overflow = signed overflow of a−b.
- op 2, AND; op 3, OR; op 4, XOR: bitwise. carry = 0, overflow = 0.
- op 5, SHIFT by one bit. dir=0: result = a<<1, carry = a[WIDTH-1]. dir=1: result = a>>1 (logical), carry = a[0]. overflow = 0. `b` is ignored.
- op 6 and op 7: result = 0, carry = 0, overflow = 0.
- zero = (result == 0) for every op.

Pipeline:
- Stage 1 registers `in_valid` and all inputs.
- Stage 2 computes the expected response from the stage-1 registers, compares it, and registers the pulses, counters and capture.

Match rules:
- A transaction matches iff result and all three flags are equal (subject to Configuration).
- Stage-1 valid = 0 produces no pulse and no counter change.

Counters and capture:
- Counters saturate at 2^CNT_WIDTH−1 and never wrap.
- First-fail capture loads only when a mismatch occurs while `err_sticky` = 0. Later mismatches increment `fail_count` but leave the `ff_*` registers unchanged.

## Timing
- Reset values (`rst` = 1 at a rising edge):
  - all outputs 0;
  - stage-1 valid 0;
  - pipeline contents discarded.
- Latency: a transaction sampled at edge k updates the pulses, counters and capture at edge k+1. The pulse is visible for the cycle that follows edge k+1.
- Throughput: one transaction per cycle; back-to-back `in_valid` is fully supported.
- `clr` at edge k+1, coinciding with a completing transaction:
  - `clr` wins: counters = 0, `err_sticky` = 0, `ff_*` = 0;
  - that transaction is not counted and produces no pulse;
  - the stage-1 register still loads new input at that edge.
- `rst` has priority over `clr`. A `rst` mid-stream drops both in-flight transactions silently.
- `pass_pulse` and `fail_pulse` are mutually exclusive.

## Configuration
- `ALU_CHK_FLAGS_EN` defined: `zero`, `carry` and `overflow` are compared in addition to `result`.
- Not defined: only `result` is compared; the flag inputs are ignored and the flag model logic is removed.

## Test plan
- ADD a=200, b=100, with a correct ALU response (result 44, carry 1, overflow 0, zero 0) -> `pass_pulse` one cycle after the sampling edge; `pass_count` = 1.
- Overflow and borrow cases, all with correct responses, `ALU_CHK_FLAGS_EN` defined -> each case passes:
  - ADD a=127, b=1 expects 128, carry 0, overflow 1;
  - SUB a=5, b=10 expects 251, carry 1, overflow 0.
- SHIFT and unused opcode, all with correct responses -> each case passes:
  - SHIFT a=0x81, dir 0 expects 0x02, carry 1;
  - SHIFT a=0x81, dir 1 expects 0x40, carry 1;
  - op 6 expects 0 with zero = 1.
- Three back-to-back transactions: correct, wrong result (AND a=0xF0, b=0x3C, got 0x31), wrong result again. Expected response:
  - `fail_count` = 2 and `err_sticky` = 1;
  - `ff_a` = 0xF0, `ff_op` = 2, `ff_exp` = 0x30, `ff_got` = 0x31, all taken from the first failure only.
- Flag-only error: ADD a=200, b=100 with `dut_carry` = 0 -> fail with `ALU_CHK_FLAGS_EN` defined; pass without it.
- With CNT_WIDTH = 4, run 20 consecutive passes, then assert `clr` in the same cycle a transaction completes -> `pass_count` holds at 15 before the clear, then reads 0 with no pulse for the cleared transaction. `rst` mid-stream -> all outputs read 0 on the next cycle.
